divpost_normshift: RTL and testbench

- Iterative left-normalization shifter for divide/sqrt results in the FPU postprocessor.
- Consumes the shift-amount interface produced by the div/sqrt shift calculation: DivShiftAmt, DivResSubnorm and DivUe, plus the raw quotient/root mantissa.
- Applies the shift over several cycles and performs the final one-bit normalization step.
- Hands the normalized mantissa and exponent to rounding through a valid/ready handshake.

---
 rtl/divpost_normshift_pkg.sv | 28 ++
 rtl/divpost_normshift_shiftstage.sv | 42 ++++
 rtl/divpost_normshift.sv | 136 +++++++++++++
 tb/tb_divpost_normshift.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/divpost_normshift_pkg.sv
// Shared constants and types for the divide/sqrt post-normalization shifter.
// config_pkg holds the FPU-wide format parameters; fpu_divpost_pkg holds the block's own types.
package config_pkg;
    localparam int NE             = 11;
    localparam int NF             = 52;
    localparam int NORMSHIFTSZ    = 128;
    localparam int LOGNORMSHIFTSZ = 8;
endpackage

package fpu_divpost_pkg;
    import config_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        NORM,
        DONE
    } state_t;

    localparam int DEF_BITSPERCYC = 2;

    // Number of SHIFT cycles needed to consume the whole shift amount.
    function automatic int num_steps(input int bpc);
        return (LOGNORMSHIFTSZ + bpc - 1) / bpc;
    endfunction

    localparam int DEF_STEPS = num_steps(DEF_BITSPERCYC);
endpackage

// File: rtl/divpost_normshift_shiftstage.sv
// One chunk of the iterative left shift: shifts by chunk << (step*B), zero-filling LSBs.
// With DIVPOST_SHIFTLOST_EN the OR of all bits pushed past the MSB is also produced.
module divpost_shiftstage #(
    parameter int W  = 128,
    parameter int B  = 2,
    parameter int SW = 2
) (
    input  logic [W-1:0]  mant_in,
    input  logic [B-1:0]  chunk,
    input  logic [SW-1:0] step,
`ifdef DIVPOST_SHIFTLOST_EN
    output logic          lost,
`endif
    output logic [W-1:0]  mant_out
);
    int shamt;

    always_comb begin
        shamt = int'(chunk) << (int'(step) * B);
    end

`ifdef DIVPOST_SHIFTLOST_EN
    logic [2*W-1:0] wide;

    always_comb begin
        wide     = '0;
        mant_out = '0;
        lost     = 1'b0;
        if (shamt >= W) begin
            lost = |mant_in;
        end else begin
            wide     = {{W{1'b0}}, mant_in} << shamt;
            mant_out = wide[W-1:0];
            lost     = |wide[2*W-1:W];
        end
    end
`else
    always_comb begin
        mant_out = mant_in << shamt;
    end
`endif
endmodule

// File: rtl/divpost_normshift.sv
// Iterative left-normalization shifter for div/sqrt results, with valid/ready output handshake.
// Optional sticky shifted-out detection is built when DIVPOST_SHIFTLOST_EN is defined.
module divpost_normshift
    import config_pkg::*;
    import fpu_divpost_pkg::*;
#(
    parameter int BITSPERCYC = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      FlushE,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [LOGNORMSHIFTSZ-1:0] DivShiftAmt,
    input  logic                      DivResSubnorm,
    input  logic [NE+1:0]             DivUe,
    input  logic [NORMSHIFTSZ-1:0]    DivMant,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [NORMSHIFTSZ-1:0]    ShiftedMant,
    output logic [NE+1:0]             UeOut,
    output logic                      ShiftLost
);
    localparam int N  = num_steps(BITSPERCYC);
    localparam int AW = N * BITSPERCYC;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int W  = NORMSHIFTSZ;
    localparam int UW = NE + 2;

    state_t              state;
    logic [SW-1:0]       step;
    logic [AW-1:0]       amt_q;
    logic [W-1:0]        mant_q;
    logic                sub_q;
    logic [UW-1:0]       ue_q;
    logic [W-1:0]        stage_mant;
    logic [BITSPERCYC-1:0] chunk;

    assign InReady = (state == IDLE) && !reset;
    assign chunk   = amt_q[step*BITSPERCYC +: BITSPERCYC];

`ifdef DIVPOST_SHIFTLOST_EN
    logic stage_lost;
    logic lost_q;

    divpost_shiftstage #(.W(W), .B(BITSPERCYC), .SW(SW)) u_stage (
        .mant_in  (mant_q),
        .chunk    (chunk),
        .step     (step),
        .lost     (stage_lost),
        .mant_out (stage_mant)
    );
`else
    divpost_shiftstage #(.W(W), .B(BITSPERCYC), .SW(SW)) u_stage (
        .mant_in  (mant_q),
        .chunk    (chunk),
        .step     (step),
        .mant_out (stage_mant)
    );

    assign ShiftLost = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            amt_q       <= '0;
            mant_q      <= '0;
            sub_q       <= 1'b0;
            ue_q        <= '0;
            OutValid    <= 1'b0;
            ShiftedMant <= '0;
            UeOut       <= '0;
`ifdef DIVPOST_SHIFTLOST_EN
            lost_q      <= 1'b0;
            ShiftLost   <= 1'b0;
`endif
        end else if (FlushE) begin
            state    <= IDLE;
            step     <= '0;
            OutValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        mant_q <= DivMant;
                        amt_q  <= AW'(DivShiftAmt);
                        sub_q  <= DivResSubnorm;
                        ue_q   <= DivUe;
                        step   <= '0;
`ifdef DIVPOST_SHIFTLOST_EN
                        lost_q <= 1'b0;
`endif
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    mant_q <= stage_mant;
`ifdef DIVPOST_SHIFTLOST_EN
                    lost_q <= lost_q | stage_lost;
`endif
                    step   <= step + SW'(1);
                    if (step == SW'(N - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    // The extra shift only happens when the MSB is 0, so NORM never loses a 1.
                    if (sub_q) begin
                        ShiftedMant <= mant_q;
                        UeOut       <= '0;
                    end else if (mant_q[W-1]) begin
                        ShiftedMant <= mant_q;
                        UeOut       <= ue_q;
                    end else begin
                        ShiftedMant <= mant_q << 1;
                        UeOut       <= ue_q - UW'(1);
                    end
`ifdef DIVPOST_SHIFTLOST_EN
                    ShiftLost   <= lost_q;
`endif
                    OutValid    <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divpost_normshift.sv
// Directed, table-driven bench for divpost_normshift plus hand-written handshake/flush/reset sequences.
module tb_divpost_normshift;
    import config_pkg::*;

    localparam int W   = NORMSHIFTSZ;
    localparam int LAT = 5;

`ifdef DIVPOST_SHIFTLOST_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      FlushE;
    logic                      InValid;
    logic                      InReady;
    logic [LOGNORMSHIFTSZ-1:0] DivShiftAmt;
    logic                      DivResSubnorm;
    logic [NE+1:0]             DivUe;
    logic [W-1:0]              DivMant;
    logic                      OutValid;
    logic                      OutReady;
    logic [W-1:0]              ShiftedMant;
    logic [NE+1:0]             UeOut;
    logic                      ShiftLost;

    int checks = 0;
    int errors = 0;

    divpost_normshift dut (
        .clk           (clk),
        .reset         (reset),
        .FlushE        (FlushE),
        .InValid       (InValid),
        .InReady       (InReady),
        .DivShiftAmt   (DivShiftAmt),
        .DivResSubnorm (DivResSubnorm),
        .DivUe         (DivUe),
        .DivMant       (DivMant),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .ShiftedMant   (ShiftedMant),
        .UeOut         (UeOut),
        .ShiftLost     (ShiftLost)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [W-1:0]      mant;
        logic [7:0]        amt;
        logic              sub;
        logic [NE+1:0]     ue;
        logic [W-1:0]      xmant;
        logic [NE+1:0]     xue;
        logic              xlost;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one operation and waits (bounded) for OutValid; leaves OutReady low.
    task automatic start_and_wait(input vec_t v, output int cnt);
        DivMant       = v.mant;
        DivShiftAmt   = v.amt;
        DivResSubnorm = v.sub;
        DivUe         = v.ue;
        InValid       = 1'b1;
        check({v.name, " in_ready_before"}, W'(InReady), W'(1));
        @(negedge clk);
        InValid = 1'b0;
        cnt = 0;
        while (!OutValid && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_result(input vec_t v, input int cnt);
        check({v.name, " latency"}, W'(cnt), W'(LAT));
        check({v.name, " mant"}, ShiftedMant, v.xmant);
        check({v.name, " ue"}, W'(UeOut), W'(v.xue));
        check({v.name, " lost"}, W'(ShiftLost), W'(v.xlost & LOST_EN));
        check({v.name, " in_ready_done"}, W'(InReady), W'(0));
    endtask

    task automatic release_out(input string name);
        OutReady = 1'b1;
        InValid  = 1'b1;
        @(negedge clk);
        OutReady = 1'b0;
        check({name, " valid_after_hs"}, W'(OutValid), W'(0));
        check({name, " in_ready_after_hs"}, W'(InReady), W'(1));
        InValid = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [W-1:0]    hold_mant;
        logic [NE+1:0]   hold_ue;
        logic            saw_valid;

        vecs[0] = '{"normal", W'(1) << (W-1-NF), 8'(NF), 1'b0, 13'd5, W'(1) << (W-1), 13'd5, 1'b0};
        vecs[1] = '{"extra_norm", W'(1) << (W-2-NF), 8'(NF), 1'b0, 13'd5, W'(1) << (W-1), 13'd4, 1'b0};
        vecs[2] = '{"subnormal", W'(16), 8'd3, 1'b1, 13'd77, W'(128), 13'd0, 1'b0};
        vecs[3] = '{"amt_zero", W'(1) << (W-1), 8'd0, 1'b0, 13'd9, W'(1) << (W-1), 13'd9, 1'b0};
        vecs[4] = '{"zero_mant", W'(0), 8'd0, 1'b0, 13'd0, W'(0), 13'h1FFF, 1'b0};
        vecs[5] = '{"amt_127", W'(1), 8'd127, 1'b0, 13'd20, W'(1) << (W-1), 13'd20, 1'b0};
        vecs[6] = '{"nibble_124", W'(15), 8'd124, 1'b0, 13'd100, W'(15) << 124, 13'd100, 1'b0};
        vecs[7] = '{"lost_msb", W'(1) << (W-1), 8'd1, 1'b0, 13'd7, W'(0), 13'd6, 1'b1};

        reset = 1'b1; FlushE = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        DivShiftAmt = '0; DivResSubnorm = 1'b0; DivUe = '0; DivMant = '0;
        repeat (3) @(negedge clk);
        check("rst in_ready", W'(InReady), W'(0));
        check("rst valid", W'(OutValid), W'(0));
        check("rst mant", ShiftedMant, W'(0));
        check("rst ue", W'(UeOut), W'(0));
        check("rst lost", W'(ShiftLost), W'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle in_ready", W'(InReady), W'(1));

        for (int i = 0; i < 8; i++) begin
            start_and_wait(vecs[i], cnt);
            check_result(vecs[i], cnt);
            release_out(vecs[i].name);
            @(negedge clk);
        end

        // Backpressure: outputs stay frozen and no new operation is accepted.
        start_and_wait(vecs[1], cnt);
        check_result(vecs[1], cnt);
        hold_mant = ShiftedMant;
        hold_ue   = UeOut;
        for (int k = 0; k < 10; k++) begin
            InValid = 1'b1;
            @(negedge clk);
            check("bp stable", {ShiftedMant[W-1:NE+3], UeOut, OutValid, InReady},
                  {hold_mant[W-1:NE+3], hold_ue, 1'b1, 1'b0});
        end
        InValid = 1'b0;
        check("bp mant", ShiftedMant, hold_mant);
        release_out("bp");
        @(negedge clk);

        // Flush during SHIFT step 2.
        DivMant = W'(1) << 10; DivShiftAmt = 8'd5; DivResSubnorm = 1'b0; DivUe = 13'd3;
        InValid = 1'b1;
        @(negedge clk);
        InValid = 1'b0;
        repeat (2) @(negedge clk);
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        check("flush in_ready", W'(InReady), W'(1));
        check("flush valid", W'(OutValid), W'(0));
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            saw_valid = saw_valid | OutValid;
        end
        check("flush no_pulse", W'(saw_valid), W'(0));
        start_and_wait(vecs[6], cnt);
        check_result(vecs[6], cnt);
        release_out("after_flush");
        @(negedge clk);

        // Reset while in NORM: state is NORM after the 4th edge past accept.
        DivMant = W'(1) << 40; DivShiftAmt = 8'd20; DivResSubnorm = 1'b0; DivUe = 13'd50;
        InValid = 1'b1;
        @(negedge clk);
        InValid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_norm valid", W'(OutValid), W'(0));
        check("rst_norm mant", ShiftedMant, W'(0));
        check("rst_norm ue", W'(UeOut), W'(0));
        check("rst_norm lost", W'(ShiftLost), W'(0));
        check("rst_norm in_ready", W'(InReady), W'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rst_norm idle", W'(InReady), W'(1));
        saw_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            saw_valid = saw_valid | OutValid;
        end
        check("rst_norm no_pulse", W'(saw_valid), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
